// File: rtl/id_ex_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage_if
//   Bundle of every signal exchanged between the ID/EX hazard stage and the
//   rest of the core (ID-stage decode fields, MEM-stage producer info, stall
//   and flush controls, registered ID_EX_* outputs and the bubble counter).
//   Clock and reset are not part of the bundle.
//
//   modport slave  : used by id_ex_hazard_stage (consumes ID fields, drives
//                    ID_EX_*, pc_write, IF_ID_write, bubble_cnt)
//   modport master : used by the surrounding core / testbench
// ---------------------------------------------------------------------------
interface id_ex_hazard_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 9
);
    // Stage controls
    logic              mem_stall;
    logic              flush;
    // ID-stage instruction
    logic              IF_ID_valid;
    logic [XLEN-1:0]   IF_ID_pc;
    logic [4:0]        IF_ID_rs1;
    logic [4:0]        IF_ID_rs2;
    logic [4:0]        IF_ID_rd;
    logic              use_rs1;
    logic              use_rs2;
    logic              jalr;
    logic [CTRL_W-1:0] ctrl_in;
    logic [XLEN-1:0]   imm_in;
    logic [XLEN-1:0]   rs1_data_in;
    logic [XLEN-1:0]   rs2_data_in;
    // MEM-stage producer
    logic [4:0]        EX_MEM_rd;
    logic              EX_MEM_memread;
    // Hazard outputs
    logic              pc_write;
    logic              IF_ID_write;
    // Registered EX-stage fields
    logic              ID_EX_valid;
    logic [XLEN-1:0]   ID_EX_pc;
    logic [4:0]        ID_EX_rs1;
    logic [4:0]        ID_EX_rs2;
    logic [4:0]        ID_EX_rd;
    logic              ID_EX_regwrite;
    logic              ID_EX_memread;
    logic [CTRL_W-1:0] ID_EX_ctrl;
    logic [XLEN-1:0]   ID_EX_imm;
    logic [XLEN-1:0]   ID_EX_rs1_data;
    logic [XLEN-1:0]   ID_EX_rs2_data;
    logic [31:0]       bubble_cnt;

    modport slave (
        input  mem_stall, flush, IF_ID_valid, IF_ID_pc, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rd, use_rs1, use_rs2, jalr, ctrl_in, imm_in,
               rs1_data_in, rs2_data_in, EX_MEM_rd, EX_MEM_memread,
        output pc_write, IF_ID_write, ID_EX_valid, ID_EX_pc, ID_EX_rs1,
               ID_EX_rs2, ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
               ID_EX_ctrl, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data,
               bubble_cnt
    );

    modport master (
        output mem_stall, flush, IF_ID_valid, IF_ID_pc, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rd, use_rs1, use_rs2, jalr, ctrl_in, imm_in,
               rs1_data_in, rs2_data_in, EX_MEM_rd, EX_MEM_memread,
        input  pc_write, IF_ID_write, ID_EX_valid, ID_EX_pc, ID_EX_rs1,
               ID_EX_rs2, ID_EX_rd, ID_EX_regwrite, ID_EX_memread,
               ID_EX_ctrl, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data,
               bubble_cnt
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
//   ID/EX pipeline register with load-use and jalr hazard detection for a
//   5-stage RV32I core. Captures the decoded ID instruction every cycle,
//   inserts a bubble when forwarding cannot resolve a dependency, holds on a
//   cache stall and squashes on a flush.
//
//   Ports:
//     clk    : core clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : id_ex_hazard_stage_if.slave (ID fields in, ID_EX_* out,
//              pc_write / IF_ID_write, bubble_cnt)
//
//   Optional feature macro: HAZARD_BUBBLE_CNT_EN
//     defined   : bubble_cnt counts hazard bubbles (wraps at 2^32)
//     undefined : bubble_cnt is tied to 0
//
//   XLEN / CTRL_W must match the parameters of the connected interface.
//   ctrl bundle: [0] regwrite, [1] memread, [2] memwrite, [3] memtoreg,
//                [4] alusrc, [8:5] aluop
// ---------------------------------------------------------------------------
module id_ex_hazard_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_hazard_stage_if.slave   bus
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;

    logic w_ex_regwrite;
    logic w_ex_memread;
    logic w_load_use;
    logic w_jalr_ex;
    logic w_jalr_ld;
    logic w_hazard;
    logic w_bubble;
    logic w_hazard_take;

    assign w_ex_regwrite = r_ctrl[0];
    assign w_ex_memread  = r_ctrl[1];

    // Hazard terms. A producer writing x0 never creates a dependency.
    assign w_load_use = r_valid & w_ex_memread & (r_rd != 5'd0) &
                        ((bus.use_rs1 & (r_rd == bus.IF_ID_rs1)) |
                         (bus.use_rs2 & (r_rd == bus.IF_ID_rs2)));

    // jalr reads rs1 in ID, so even an ALU result one stage ahead is too late.
    assign w_jalr_ex  = bus.jalr & r_valid & w_ex_regwrite & (r_rd != 5'd0) &
                        (r_rd == bus.IF_ID_rs1);

    // A load in MEM has no data until the end of MEM: a second jalr bubble.
    assign w_jalr_ld  = bus.jalr & bus.EX_MEM_memread & (bus.EX_MEM_rd != 5'd0) &
                        (bus.EX_MEM_rd == bus.IF_ID_rs1);

    assign w_hazard   = bus.IF_ID_valid & ~bus.flush &
                        (w_load_use | w_jalr_ex | w_jalr_ld);

    assign w_bubble      = bus.flush | w_hazard;
    assign w_hazard_take = ~bus.mem_stall & w_hazard;

    // Front-end handshake: pc_write / IF_ID_write are "ready" signals for the
    // IF side. When 1, the instruction in ID is consumed at this edge (loaded
    // into EX or squashed by flush) and PC / IF/ID may advance. When 0
    // (mem_stall or an unresolved hazard) the front end must hold its state.
    assign bus.pc_write    = ~bus.mem_stall & ~w_hazard;
    assign bus.IF_ID_write = ~bus.mem_stall & ~w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (!bus.mem_stall) begin
            // pc/imm/data are don't-care in a bubble, so load them always.
            r_pc       <= bus.IF_ID_pc;
            r_imm      <= bus.imm_in;
            r_rs1_data <= bus.rs1_data_in;
            r_rs2_data <= bus.rs2_data_in;
            if (w_bubble) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_rd    <= '0;
                r_rs1   <= '0;
                r_rs2   <= '0;
            end else begin
                r_valid <= bus.IF_ID_valid;
                r_ctrl  <= bus.ctrl_in;
                r_rd    <= bus.IF_ID_rd;
                r_rs1   <= bus.IF_ID_rs1;
                r_rs2   <= bus.IF_ID_rs2;
            end
        end
    end

`ifdef HAZARD_BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Counts only hazard bubbles; flush squashes and stall holds are excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_hazard_take) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bus.bubble_cnt = r_bubble_cnt;
`else
    assign bus.bubble_cnt = 32'd0;
`endif

    assign bus.ID_EX_valid    = r_valid;
    assign bus.ID_EX_pc       = r_pc;
    assign bus.ID_EX_rs1      = r_rs1;
    assign bus.ID_EX_rs2      = r_rs2;
    assign bus.ID_EX_rd       = r_rd;
    assign bus.ID_EX_regwrite = w_ex_regwrite;
    assign bus.ID_EX_memread  = w_ex_memread;
    assign bus.ID_EX_ctrl     = r_ctrl;
    assign bus.ID_EX_imm      = r_imm;
    assign bus.ID_EX_rs1_data = r_rs1_data;
    assign bus.ID_EX_rs2_data = r_rs2_data;

`ifndef HAZARD_BUBBLE_CNT_EN
    logic w_unused;
    assign w_unused = w_hazard_take;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
module tb_id_ex_hazard_stage;

  localparam int XLEN = 32;
  localparam int CW   = 9;

  // Control bundles: [0] regwrite [1] memread [3] memtoreg [4] alusrc [8:5] aluop
  localparam logic [8:0] C_LW   = 9'h01B;
  localparam logic [8:0] C_ADD  = 9'h041;
  localparam logic [8:0] C_JALR = 9'h011;

  localparam int K_LOAD  = 0;
  localparam int K_FLUSH = 1;
  localparam int K_HAZ   = 2;
  localparam int K_HOLD  = 3;

  // Expected record: pcw, ifw, valid, rs1, rs2, rd, ctrl, pc, imm, d1, d2, cnt
  localparam int EW = 3 + 15 + CW + 5 * 32;

  logic clk;
  logic rst_n;

  id_ex_hazard_stage_if #(.XLEN(XLEN), .CTRL_W(CW)) bus();

  id_ex_hazard_stage #(.XLEN(XLEN), .CTRL_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;
  logic mon_busy;

  // Reference state of the EX-stage register, advanced by the driver.
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [8:0]  m_ctrl;
  logic [31:0] m_pc, m_imm, m_d1, m_d2, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [31:0] pc,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic u1, input logic u2, input logic jr, input logic [8:0] ctrl,
                      input logic [4:0] xm_rd, input logic xm_mr,
                      input logic st, input logic fl, input int kind);
    logic e_pcw;
    logic [31:0] imm, d1, d2;
    @(negedge clk);
    imm = pc + 32'h0000_1000;
    d1  = {pc[15:0], 16'h1111};
    d2  = ~pc;
    bus.IF_ID_valid    = v;
    bus.IF_ID_pc       = pc;
    bus.IF_ID_rs1      = rs1;
    bus.IF_ID_rs2      = rs2;
    bus.IF_ID_rd       = rd;
    bus.use_rs1        = u1;
    bus.use_rs2        = u2;
    bus.jalr           = jr;
    bus.ctrl_in        = ctrl;
    bus.imm_in         = imm;
    bus.rs1_data_in    = d1;
    bus.rs2_data_in    = d2;
    bus.EX_MEM_rd      = xm_rd;
    bus.EX_MEM_memread = xm_mr;
    bus.mem_stall      = st;
    bus.flush          = fl;
    if (kind != K_HOLD) begin
      m_pc = pc; m_imm = imm; m_d1 = d1; m_d2 = d2;
      if (kind == K_LOAD) begin
        m_valid = v; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_ctrl = ctrl;
      end else begin
        m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
      end
    end
`ifdef HAZARD_BUBBLE_CNT_EN
    if (kind == K_HAZ) m_cnt = m_cnt + 32'd1;
`endif
    e_pcw = (kind == K_LOAD) || (kind == K_FLUSH);
    exp_q.push_back({e_pcw, e_pcw, m_valid, m_rs1, m_rs2, m_rd, m_ctrl,
                     m_pc, m_imm, m_d1, m_d2, m_cnt});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] item;
    logic        e_pcw, e_ifw, e_valid;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [8:0]  e_ctrl;
    logic [31:0] e_pc, e_imm, e_d1, e_d2, e_cnt;
    logic        a_pcw, a_ifw;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mon_busy = 1'b1;
        item = exp_q.pop_front();
        {e_pcw, e_ifw, e_valid, e_rs1, e_rs2, e_rd, e_ctrl,
         e_pc, e_imm, e_d1, e_d2, e_cnt} = item;
        a_pcw = bus.pc_write;
        a_ifw = bus.IF_ID_write;
        @(posedge clk);
        #1;
        chk("pc_write",       {31'd0, a_pcw},               {31'd0, e_pcw});
        chk("IF_ID_write",    {31'd0, a_ifw},               {31'd0, e_ifw});
        chk("ID_EX_valid",    {31'd0, bus.ID_EX_valid},     {31'd0, e_valid});
        chk("ID_EX_rs1",      {27'd0, bus.ID_EX_rs1},       {27'd0, e_rs1});
        chk("ID_EX_rs2",      {27'd0, bus.ID_EX_rs2},       {27'd0, e_rs2});
        chk("ID_EX_rd",       {27'd0, bus.ID_EX_rd},        {27'd0, e_rd});
        chk("ID_EX_ctrl",     {23'd0, bus.ID_EX_ctrl},      {23'd0, e_ctrl});
        chk("ID_EX_regwrite", {31'd0, bus.ID_EX_regwrite},  {31'd0, e_ctrl[0]});
        chk("ID_EX_memread",  {31'd0, bus.ID_EX_memread},   {31'd0, e_ctrl[1]});
        chk("bubble_cnt",     bus.bubble_cnt,               e_cnt);
        if (e_valid) begin
          chk("ID_EX_pc",       bus.ID_EX_pc,       e_pc);
          chk("ID_EX_imm",      bus.ID_EX_imm,      e_imm);
          chk("ID_EX_rs1_data", bus.ID_EX_rs1_data, e_d1);
          chk("ID_EX_rs2_data", bus.ID_EX_rs2_data, e_d2);
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit drained;
    checks = 0;
    errors = 0;
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0; m_cnt = 0;
    bus.IF_ID_valid = 0; bus.IF_ID_pc = 0; bus.IF_ID_rs1 = 0; bus.IF_ID_rs2 = 0;
    bus.IF_ID_rd = 0; bus.use_rs1 = 0; bus.use_rs2 = 0; bus.jalr = 0;
    bus.ctrl_in = 0; bus.imm_in = 0; bus.rs1_data_in = 0; bus.rs2_data_in = 0;
    bus.EX_MEM_rd = 0; bus.EX_MEM_memread = 0; bus.mem_stall = 0; bus.flush = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid",    {31'd0, bus.ID_EX_valid}, 32'd0);
    chk("reset_ctrl",     {23'd0, bus.ID_EX_ctrl},  32'd0);
    chk("reset_rd",       {27'd0, bus.ID_EX_rd},    32'd0);
    chk("reset_pc",       bus.ID_EX_pc,             32'd0);
    chk("reset_cnt",      bus.bubble_cnt,           32'd0);
    chk("reset_pc_write", {31'd0, bus.pc_write},    32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    //    v  pc             rs1 rs2 rd u1 u2 jr ctrl    xmrd xmmr st fl kind
    // Load-use: lw x5 then add x6,x5
    step(1, 32'h0000_0100, 1, 0, 5, 1, 0, 0, C_LW,   0, 0, 0, 0, K_LOAD);
    step(1, 32'h0000_0104, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 0, 0, K_HAZ);
    step(1, 32'h0000_0104, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 0, 0, K_LOAD);
    // x0 exemption: lw x0 then add reading x0
    step(1, 32'h0000_0108, 2, 0, 0, 1, 0, 0, C_LW,   0, 0, 0, 0, K_LOAD);
    step(1, 32'h0000_010C, 0, 0, 7, 1, 0, 0, C_ADD,  0, 0, 0, 0, K_LOAD);
    // jalr after load: two bubbles (jalr_ex, then jalr_ld)
    step(1, 32'h0000_0110, 3, 0, 7, 1, 0, 0, C_LW,   0, 0, 0, 0, K_LOAD);
    step(1, 32'h0000_0114, 7, 0, 1, 1, 0, 1, C_JALR, 7, 0, 0, 0, K_HAZ);
    step(1, 32'h0000_0114, 7, 0, 1, 1, 0, 1, C_JALR, 7, 1, 0, 0, K_HAZ);
    step(1, 32'h0000_0114, 7, 0, 1, 1, 0, 1, C_JALR, 0, 0, 0, 0, K_LOAD);
    // jalr after ALU producer: one bubble
    step(1, 32'h0000_0118, 1, 0, 9, 1, 0, 0, C_ADD,  0, 0, 0, 0, K_LOAD);
    step(1, 32'h0000_011C, 9, 0, 1, 1, 0, 1, C_JALR, 1, 0, 0, 0, K_HAZ);
    step(1, 32'h0000_011C, 9, 0, 1, 1, 0, 1, C_JALR, 9, 0, 0, 0, K_LOAD);
    // Flush together with load-use: bubble, front end proceeds, no count
    step(1, 32'h0000_0120, 2, 0, 5, 1, 0, 0, C_LW,   1, 0, 0, 0, K_LOAD);
    step(1, 32'h0000_0124, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 0, 1, K_FLUSH);
    // mem_stall over a pending load-use: 3 holds then exactly one bubble
    step(1, 32'h0000_0128, 2, 0, 5, 1, 0, 0, C_LW,   0, 0, 0, 0, K_LOAD);
    step(1, 32'h0000_012C, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 1, 0, K_HOLD);
    step(1, 32'h0000_012C, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 1, 0, K_HOLD);
    step(1, 32'h0000_012C, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 1, 0, K_HOLD);
    step(1, 32'h0000_012C, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 0, 0, K_HAZ);
    step(1, 32'h0000_012C, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 0, 0, K_LOAD);
    // IF_ID_valid=0 never stalls; ctrl still loaded with valid=0
    step(1, 32'h0000_0130, 2, 0, 5, 1, 0, 0, C_LW,   0, 0, 0, 0, K_LOAD);
    step(0, 32'h0000_0134, 5, 0, 6, 1, 0, 0, C_ADD,  0, 0, 0, 0, K_LOAD);
    // Load-use through rs2
    step(1, 32'h0000_0138, 1, 0, 8, 1, 0, 0, C_LW,   0, 0, 0, 0, K_LOAD);
    step(1, 32'h0000_013C, 1, 8, 4, 1, 1, 0, C_ADD,  0, 0, 0, 0, K_HAZ);
    step(1, 32'h0000_013C, 1, 8, 4, 1, 1, 0, C_ADD,  0, 0, 0, 0, K_LOAD);
    // Valid instruction in EX ahead of the reset test
    step(1, 32'h0000_0140, 2, 0, 5, 1, 0, 0, C_LW,   0, 0, 0, 0, K_LOAD);

    drained = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0 && !mon_busy) begin
        drained = 1;
        break;
      end
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end

    // Async reset in the middle of a stall
    @(negedge clk);
    bus.mem_stall = 1'b1;
    @(posedge clk);
    #2;
    chk("stall_hold_valid", {31'd0, bus.ID_EX_valid}, 32'd1);
    chk("stall_hold_pc",    bus.ID_EX_pc,             32'h0000_0140);
    chk("stall_pc_write",   {31'd0, bus.pc_write},    32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    {31'd0, bus.ID_EX_valid},    32'd0);
    chk("arst_pc",       bus.ID_EX_pc,                32'd0);
    chk("arst_rd",       {27'd0, bus.ID_EX_rd},       32'd0);
    chk("arst_ctrl",     {23'd0, bus.ID_EX_ctrl},     32'd0);
    chk("arst_imm",      bus.ID_EX_imm,               32'd0);
    chk("arst_rs1_data", bus.ID_EX_rs1_data,          32'd0);
    chk("arst_cnt",      bus.bubble_cnt,              32'd0);
    @(negedge clk);
    bus.mem_stall   = 1'b0;
    bus.IF_ID_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("release_valid", {31'd0, bus.ID_EX_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_release_valid", {31'd0, bus.ID_EX_valid}, 32'd0);
    chk("post_release_cnt",   bus.bubble_cnt,           32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register combined with load-use and jalr hazard detection for the 5-stage RV32I core. It captures decoded ID-stage fields each cycle and drives the ID_EX_* signals consumed by the forwarding unit and the EX stage. When a forwarding path cannot resolve a dependency, it inserts a bubble and freezes PC and IF/ID. On a cache stall it holds its whole state; on a flush it squashes.

Parameters:
XLEN, 32, datapath width (pc, operands, immediate)
CTRL_W, 9, width of ctrl bundle: [0] regwrite, [1] memread, [2] memwrite, [3] memtoreg, [4] alusrc, [8:5] aluop

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_stall  in  1  I/D cache miss; freeze this stage
flush  in  1  taken branch/jump resolved; squash ID instruction
IF_ID_valid  in  1  ID stage holds a real instruction
IF_ID_pc  in  XLEN  pc of ID instruction
IF_ID_rs1  in  5  source reg 1 index
IF_ID_rs2  in  5  source reg 2 index
IF_ID_rd  in  5  destination index
use_rs1  in  1  instruction reads rs1
use_rs2  in  1  instruction reads rs2
jalr  in  1  ID instruction is jalr (target computed in ID)
ctrl_in  in  CTRL_W  decoded control bundle
imm_in  in  XLEN  decoded immediate
rs1_data_in  in  XLEN  register file read port 1
rs2_data_in  in  XLEN  register file read port 2
EX_MEM_rd  in  5  rd in MEM stage
EX_MEM_memread  in  1  MEM-stage instruction is a load
pc_write  out  1  1 = PC may update
IF_ID_write  out  1  1 = IF/ID may load
ID_EX_valid  out  1  EX holds a real instruction
ID_EX_pc  out  XLEN  registered pc
ID_EX_rs1  out  5  registered rs1 (to forwarding unit)
ID_EX_rs2  out  5  registered rs2
ID_EX_rd  out  5  registered rd
ID_EX_regwrite  out  1  registered ctrl[0]
ID_EX_memread  out  1  registered ctrl[1]
ID_EX_ctrl  out  CTRL_W  full registered bundle
ID_EX_imm  out  XLEN  registered immediate
ID_EX_rs1_data  out  XLEN  registered operand 1
ID_EX_rs2_data  out  XLEN  registered operand 2
bubble_cnt  out  32  bubbles inserted (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs are 0 and ID_EX_valid is 0. This takes effect immediately, including mid-stall.
- Hazard terms (combinational; a term is 0 when its rd==0):
  - load_use = ID_EX_valid & ID_EX_memread & ((use_rs1 & ID_EX_rd==IF_ID_rs1) | (use_rs2 & ID_EX_rd==IF_ID_rs2))
  - jalr_ex = jalr & ID_EX_valid & ID_EX_regwrite & ID_EX_rd==IF_ID_rs1
  - jalr_ld = jalr & EX_MEM_memread & EX_MEM_rd==IF_ID_rs1
  - hazard = IF_ID_valid & ~flush & (load_use | jalr_ex | jalr_ld)
- Per-edge priority:
  1. mem_stall: hold all ID_EX_* registers; pc_write=0, IF_ID_write=0.
  2. flush: load a bubble; pc_write=1, IF_ID_write=1.
  3. hazard: load a bubble; pc_write=0, IF_ID_write=0.
  4. Otherwise: load all inputs; ID_EX_valid=IF_ID_valid; pc_write=1, IF_ID_write=1.
- Bubble: ID_EX_valid=0, ID_EX_ctrl=0 (so regwrite and memread are 0), ID_EX_rd/rs1/rs2=0. pc, imm and data are loaded normally; they are don't-care.
- Latency: one cycle ID->EX. Load-use costs exactly 1 bubble. jalr after an ALU producer costs 1 bubble. jalr directly after a load costs 2 bubbles (jalr_ex, then jalr_ld).
- IF_ID_valid=0 never stalls and loads a bubble-equivalent (ctrl_in still loaded, valid=0).

Optional Feature:
HAZARD_BUBBLE_CNT_EN
- Defined: bubble_cnt increments by 1 on every edge that takes priority 3 (hazard bubble). It is not incremented for flush or mem_stall. It wraps at 2^32 and resets to 0.
- Undefined: no counter logic; bubble_cnt is tied to 0.

Test Plan:
- Load-use: ID_EX holds lw rd=5 (memread=1). ID holds add rs1=5, use_rs1=1. Expect pc_write=IF_ID_write=0 for 1 cycle and ID_EX_valid=0 next edge. On the following edge ID_EX_rs1=5, ID_EX_valid=1.
- jalr after load: lw x7 then jalr rs1=7. Expect 2 consecutive stall cycles (jalr_ex, then jalr_ld), then jalr enters EX. bubble_cnt=2 when the feature is enabled.
- x0 exemption: ID_EX lw rd=0, ID uses rs1=0. Expect no stall; pc_write stays 1.
- flush with hazard in same cycle: load_use true and flush=1. Expect bubble, pc_write=1, bubble_cnt unchanged.
- mem_stall during hazard: mem_stall=1 for 3 cycles with ID_EX lw x5. Expect ID_EX_* constant and pc_write=0. After release, exactly 1 hazard bubble.
- Async reset mid-stall: drop rst_n between edges. Expect all ID_EX_* and bubble_cnt = 0 immediately, and ID_EX_valid=0 after release.
